// File: rtl/servo_frame_sequencer_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | servo_frame_sequencer_if                                                   |
// | Position inputs and pulse/status outputs of the servo frame sequencer.     |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
interface servo_frame_sequencer_if #(
  parameter int NUM_CH = 8
);
  localparam int c_CHW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic                enable;
  logic [8*NUM_CH-1:0] dutyIn;
  logic [NUM_CH-1:0]   pwmOut;
  logic                frameStart;
  logic [c_CHW-1:0]    activeCh;
  logic                busy;

  modport master (
    output enable,
    output dutyIn,
    input  pwmOut,
    input  frameStart,
    input  activeCh,
    input  busy
  );

  modport slave (
    input  enable,
    input  dutyIn,
    output pwmOut,
    output frameStart,
    output activeCh,
    output busy
  );
endinterface
`default_nettype wire

// File: rtl/servo_frame_sequencer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | servo_frame_sequencer                                                      |
// | Time-multiplexed servo pulse scheduler with per-frame shadowed positions.  |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module servo_frame_sequencer #(
  parameter int NUM_CH      = 8,
  parameter int TICK_DIV    = 50,
  parameter int MIN_TICKS   = 1000,
  parameter int SCALE_SHIFT = 2,
  parameter int GAP_TICKS   = 10,
  parameter int FRAME_TICKS = 20000
) (
  input  logic                   clk,
  input  logic                   resetN,
  servo_frame_sequencer_if.slave bus
);

  localparam int c_CHW      = $clog2(NUM_CH);
  localparam int c_PW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int c_FW       = $clog2(FRAME_TICKS + 1);
  localparam int c_SLOT_MAX = MIN_TICKS + (255 << SCALE_SHIFT) + GAP_TICKS;

  localparam logic [c_PW-1:0]   c_PRESC_LAST = c_PW'(TICK_DIV - 1);
  localparam logic [c_FW-1:0]   c_FRAME_LAST = c_FW'(FRAME_TICKS - 1);
  localparam logic [15:0]       c_MIN        = 16'(MIN_TICKS);
  localparam logic [15:0]       c_GAP_LAST   = 16'(GAP_TICKS - 1);
  localparam logic [c_CHW-1:0]  c_LAST_CH    = c_CHW'(NUM_CH - 1);
  localparam logic [NUM_CH-1:0] c_CH0        = NUM_CH'(1);

  generate
    if (NUM_CH < 2 || NUM_CH > 16 || TICK_DIV < 1 || MIN_TICKS < 1 || GAP_TICKS < 1 ||
        NUM_CH * c_SLOT_MAX >= FRAME_TICKS) begin : g_param_check
      $error("servo_frame_sequencer: parameter set cannot fit every channel in one frame");
    end
  endgenerate

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_PULSE = 3'd2,
    ST_GAP   = 3'd3,
    ST_WAIT  = 3'd4
  } state_t;

  state_t             r_state;
  logic [c_PW-1:0]    r_presc;
  logic [15:0]        r_width;
  logic [c_FW-1:0]    r_frame;
  logic [c_CHW-1:0]   r_ch;
  logic [NUM_CH-1:0]  r_pwm;
  logic               r_frame_start;
  logic               r_busy;
  logic [7:0]         r_shadow [NUM_CH];

  logic               w_counting;
  logic               w_presc_wrap;
  logic [c_PW-1:0]    w_presc_next;
  logic               w_tick;
  logic               w_pre_tick;
  logic [c_FW-1:0]    w_frame_ticks;
  logic               w_frame_end;
  logic [7:0]         w_duty;
  logic [15:0]        w_width_last;
  logic [c_CHW-1:0]   w_ch_next;
  logic [NUM_CH-1:0]  w_next_pwm;

  assign w_counting   = (r_state == ST_PULSE) || (r_state == ST_GAP) || (r_state == ST_WAIT);
  assign w_presc_wrap = (r_presc == c_PRESC_LAST);
  assign w_presc_next = w_presc_wrap ? '0 : r_presc + c_PW'(1);
  assign w_tick       = w_counting && w_presc_wrap;

  // The LOAD clk is part of the frame but precedes the first tick period, so the
  // frame closes one clk before its last tick boundary: on the clk whose successor
  // would be the final tick.
  assign w_pre_tick    = (w_presc_next == c_PRESC_LAST);
  assign w_frame_ticks = r_frame + {{(c_FW-1){1'b0}}, w_tick};
  assign w_frame_end   = w_pre_tick && (w_frame_ticks == c_FRAME_LAST);

  assign w_duty       = r_shadow[r_ch];
  assign w_width_last = c_MIN + ({8'd0, w_duty} << SCALE_SHIFT) - 16'd1;
  assign w_ch_next    = r_ch + c_CHW'(1);
  assign w_next_pwm   = c_CH0 << w_ch_next;

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_state       <= ST_IDLE;
      r_presc       <= '0;
      r_width       <= '0;
      r_frame       <= '0;
      r_ch          <= '0;
      r_pwm         <= '0;
      r_frame_start <= 1'b0;
      r_busy        <= 1'b0;
      for (int k = 0; k < NUM_CH; k++) begin
        r_shadow[k] <= '0;
      end
    end else begin
      r_frame_start <= 1'b0;

      if (w_counting) begin
        r_presc <= w_presc_next;
        if (w_tick) begin
          r_frame <= r_frame + c_FW'(1);
        end
      end else begin
        r_presc <= '0;
      end

      case (r_state)
        ST_IDLE: begin
          if (bus.enable) begin
            r_state       <= ST_LOAD;
            r_frame_start <= 1'b1;
            r_busy        <= 1'b1;
          end
        end

        ST_LOAD: begin
          for (int k = 0; k < NUM_CH; k++) begin
            r_shadow[k] <= bus.dutyIn[8*k +: 8];
          end
          r_frame <= '0;
          r_width <= '0;
          r_ch    <= '0;
          r_pwm   <= c_CH0;
          r_state <= ST_PULSE;
        end

        ST_PULSE: begin
          if (w_tick) begin
            if (r_width == w_width_last) begin
              r_width <= '0;
              r_pwm   <= '0;
              r_state <= ST_GAP;
            end else begin
              r_width <= r_width + 16'd1;
            end
          end
        end

        ST_GAP: begin
          if (w_tick) begin
            if (r_width == c_GAP_LAST) begin
              r_width <= '0;
              if (r_ch != c_LAST_CH) begin
                r_ch    <= w_ch_next;
                r_pwm   <= w_next_pwm;
                r_state <= ST_PULSE;
              end else if (w_frame_end) begin
                // Tightest packing: the last gap ends on the final clk of the frame.
                r_presc <= '0;
                if (bus.enable) begin
                  r_state       <= ST_LOAD;
                  r_frame_start <= 1'b1;
                end else begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
                end
              end else begin
                r_state <= ST_WAIT;
              end
            end else begin
              r_width <= r_width + 16'd1;
            end
          end
        end

        ST_WAIT: begin
          if (w_frame_end) begin
            r_presc <= '0;
            if (bus.enable) begin
              r_state       <= ST_LOAD;
              r_frame_start <= 1'b1;
            end else begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end

        default: begin
          r_state <= ST_IDLE;
          r_pwm   <= '0;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.pwmOut     = r_pwm;
  assign bus.frameStart = r_frame_start;
  assign bus.activeCh   = r_ch;
  assign bus.busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_servo_frame_sequencer.sv
`default_nettype none
// Scoreboard bench: expected pulses are queued as stimulus is applied and
// checked by a pulse monitor; scenario tasks check frame-level timing inline.
module tb_servo_frame_sequencer;

  localparam int NCH        = 4;
  localparam int PERIOD     = 10;
  localparam int BASE_FRAME = 1100;
  localparam int XTR_FRAME  = 5000;

  logic clk = 1'b0;
  logic resetN;
  always #5 clk = ~clk;

  servo_frame_sequencer_if #(.NUM_CH(NCH)) ifa ();
  servo_frame_sequencer_if #(.NUM_CH(NCH)) ifx ();
  servo_frame_sequencer_if #(.NUM_CH(NCH)) ifp ();

  servo_frame_sequencer #(
    .NUM_CH(NCH), .TICK_DIV(1), .MIN_TICKS(10), .SCALE_SHIFT(0),
    .GAP_TICKS(2), .FRAME_TICKS(BASE_FRAME)
  ) dut_a (.clk(clk), .resetN(resetN), .bus(ifa.slave));

  servo_frame_sequencer #(
    .NUM_CH(NCH), .TICK_DIV(1), .MIN_TICKS(10), .SCALE_SHIFT(2),
    .GAP_TICKS(2), .FRAME_TICKS(XTR_FRAME)
  ) dut_x (.clk(clk), .resetN(resetN), .bus(ifx.slave));

  servo_frame_sequencer #(
    .NUM_CH(NCH), .TICK_DIV(3), .MIN_TICKS(10), .SCALE_SHIFT(0),
    .GAP_TICKS(2), .FRAME_TICKS(BASE_FRAME)
  ) dut_p (.clk(clk), .resetN(resetN), .bus(ifp.slave));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    int ch;
    int width;
    int lead;
    bit from_fs;
  } exp_t;

  exp_t exp_q[$];
  time  fs_q[$];

  int sel = 0;
  logic [NCH-1:0] m_pwm;
  logic           m_fs;
  logic           m_busy;
  logic [1:0]     m_ach;

  always_comb begin
    case (sel)
      1: begin m_pwm = ifx.pwmOut; m_fs = ifx.frameStart; m_busy = ifx.busy; m_ach = ifx.activeCh; end
      2: begin m_pwm = ifp.pwmOut; m_fs = ifp.frameStart; m_busy = ifp.busy; m_ach = ifp.activeCh; end
      default: begin m_pwm = ifa.pwmOut; m_fs = ifa.frameStart; m_busy = ifa.busy; m_ach = ifa.activeCh; end
    endcase
  end

  // Pulse monitor: measures every completed pulse of the selected DUT in clks.
  int cyc = 0;
  int onehot_bad = 0;
  int rise_cyc = 0, rise_ch = 0, lead_fs = 0, lead_gap = 0;
  int last_fs = 0, last_fall = 0;
  logic [NCH-1:0] prev_pwm = '0;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if ($countones(ifa.pwmOut) > 1 || $countones(ifx.pwmOut) > 1 ||
          $countones(ifp.pwmOut) > 1) onehot_bad++;
      if (!resetN) begin
        prev_pwm = '0;
      end else begin
        if (m_fs) begin
          fs_q.push_back($time);
          last_fs = cyc;
        end
        if (m_pwm !== prev_pwm) begin
          if (prev_pwm != '0) begin
            int w;
            w = cyc - rise_cyc;
            checks++;
            if (exp_q.size() == 0) begin
              failures++;
              $display("FAIL pulse_unexpected: got ch=%0d width=%0d, expected no pulse", rise_ch, w);
            end else begin
              exp_t e;
              int   lead;
              e = exp_q.pop_front();
              lead = e.from_fs ? lead_fs : lead_gap;
              if (rise_ch !== e.ch || w !== e.width || lead !== e.lead) begin
                failures++;
                $display("FAIL pulse: got ch=%0d width=%0d lead=%0d, expected ch=%0d width=%0d lead=%0d",
                         rise_ch, w, lead, e.ch, e.width, e.lead);
              end
            end
            last_fall = cyc;
          end
          if (m_pwm != '0) begin
            for (int i = 0; i < NCH; i++) if (m_pwm[i]) rise_ch = i;
            rise_cyc = cyc;
            lead_fs  = cyc - last_fs;
            lead_gap = cyc - last_fall;
            checks++;
            if (int'(m_ach) !== rise_ch) begin
              failures++;
              $display("FAIL active_ch: got %0d expected %0d", m_ach, rise_ch);
            end
          end
        end
        prev_pwm = m_pwm;
      end
    end
  end

  // Reference model of one frame: width = (MIN + duty<<SHIFT) ticks of TD clks.
  task automatic push_frame(input int d0, input int d1, input int d2, input int d3,
                            input int min_t, input int shift, input int gap, input int td);
    int d[4];
    d = '{d0, d1, d2, d3};
    for (int c = 0; c < 4; c++) begin
      exp_t e;
      e.ch      = c;
      e.width   = (min_t + (d[c] << shift)) * td;
      e.from_fs = (c == 0);
      e.lead    = (c == 0) ? 1 : gap * td;
      exp_q.push_back(e);
    end
  endtask

  task automatic test_reset();
    resetN = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (ifa.pwmOut !== 4'd0) begin failures++; $display("FAIL reset_pwm: got %b expected 0000", ifa.pwmOut); end
    checks++; if (ifa.frameStart !== 1'b0) begin failures++; $display("FAIL reset_fs: got %b expected 0", ifa.frameStart); end
    checks++; if (ifa.activeCh !== 2'd0) begin failures++; $display("FAIL reset_ach: got %0d expected 0", ifa.activeCh); end
    checks++; if (ifa.busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", ifa.busy); end
    resetN = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (ifa.busy !== 1'b0 || ifa.frameStart !== 1'b0) begin
      failures++; $display("FAIL idle_hold: got busy=%b fs=%b expected 0 0", ifa.busy, ifa.frameStart);
    end
  endtask

  task automatic test_basic_frame();
    int dt;
    sel = 0; exp_q.delete(); fs_q.delete();
    ifa.dutyIn = {8'd4, 8'd3, 8'd2, 8'd1};
    push_frame(1, 2, 3, 4, 10, 0, 2, 1);
    push_frame(1, 2, 3, 4, 10, 0, 2, 1);
    ifa.enable = 1'b1;
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL basic_timeout: got %0d pending expected 0", exp_q.size()); end
    dt = (fs_q.size() >= 2) ? int'((fs_q[1] - fs_q[0]) / PERIOD) : -1;
    checks++; if (dt !== BASE_FRAME) begin failures++; $display("FAIL basic_frame_period: got %0d expected %0d", dt, BASE_FRAME); end
    checks++; if (ifa.busy !== 1'b1) begin failures++; $display("FAIL basic_busy: got %b expected 1", ifa.busy); end
    ifa.enable = 1'b0;
    for (int i = 0; i < 2500 && ifa.busy !== 1'b0; i++) @(negedge clk);
    checks++; if (ifa.busy !== 1'b0) begin failures++; $display("FAIL basic_idle: got busy=%b expected 0", ifa.busy); end
  endtask

  task automatic test_shadow_latch();
    sel = 0; exp_q.delete(); fs_q.delete();
    ifa.dutyIn = {8'd4, 8'd3, 8'd2, 8'd1};
    push_frame(1, 2, 3, 4, 10, 0, 2, 1);
    ifa.enable = 1'b1;
    for (int i = 0; i < 100 && ifa.pwmOut[0] !== 1'b1; i++) @(negedge clk);
    checks++; if (ifa.pwmOut[0] !== 1'b1) begin failures++; $display("FAIL shadow_start: got pwm=%b expected ch0 high", ifa.pwmOut); end
    ifa.dutyIn[23:16] = 8'd50;
    push_frame(1, 2, 50, 4, 10, 0, 2, 1);
    for (int i = 0; i < 3000 && exp_q.size() != 0; i++) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL shadow_timeout: got %0d pending expected 0", exp_q.size()); end
    ifa.enable = 1'b0;
    for (int i = 0; i < 2500 && ifa.busy !== 1'b0; i++) @(negedge clk);
    checks++; if (ifa.busy !== 1'b0) begin failures++; $display("FAIL shadow_idle: got busy=%b expected 0", ifa.busy); end
  endtask

  task automatic test_enable_drop();
    time t_fall;
    int  dt;
    sel = 0; exp_q.delete(); fs_q.delete();
    ifa.dutyIn = {8'd4, 8'd3, 8'd2, 8'd1};
    push_frame(1, 2, 3, 4, 10, 0, 2, 1);
    ifa.enable = 1'b1;
    for (int i = 0; i < 100 && ifa.pwmOut[1] !== 1'b1; i++) @(negedge clk);
    ifa.enable = 1'b0;
    for (int i = 0; i < 2500 && ifa.busy !== 1'b0; i++) @(negedge clk);
    t_fall = $time;
    dt = (fs_q.size() >= 1) ? int'((t_fall - fs_q[0]) / PERIOD) : -1;
    checks++; if (dt !== BASE_FRAME) begin failures++; $display("FAIL drop_busy_fall: got %0d clks expected %0d", dt, BASE_FRAME); end
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL drop_pulses: got %0d pending expected 0", exp_q.size()); end
    repeat (1300) @(negedge clk);
    checks++; if (fs_q.size() != 1) begin failures++; $display("FAIL drop_no_restart: got %0d strobes expected 1", fs_q.size()); end
  endtask

  task automatic test_async_reset();
    sel = 0; exp_q.delete(); fs_q.delete();
    ifa.dutyIn = {8'd4, 8'd3, 8'd2, 8'd1};
    push_frame(1, 2, 3, 4, 10, 0, 2, 1);
    ifa.enable = 1'b1;
    for (int i = 0; i < 200 && ifa.pwmOut[2] !== 1'b1; i++) @(negedge clk);
    checks++; if (ifa.pwmOut[2] !== 1'b1) begin failures++; $display("FAIL areset_pre: got pwm=%b expected ch2 high", ifa.pwmOut); end
    #2 resetN = 1'b0;
    #1;
    checks++; if (ifa.pwmOut !== 4'd0) begin failures++; $display("FAIL areset_pwm: got %b expected 0000", ifa.pwmOut); end
    checks++; if (ifa.busy !== 1'b0 || ifa.activeCh !== 2'd0) begin
      failures++; $display("FAIL areset_state: got busy=%b ach=%0d expected 0 0", ifa.busy, ifa.activeCh);
    end
    @(negedge clk);
    #2 resetN = 1'b1;
    exp_q.delete(); fs_q.delete();
    push_frame(1, 2, 3, 4, 10, 0, 2, 1);
    @(negedge clk);
    checks++; if (ifa.frameStart !== 1'b1) begin failures++; $display("FAIL areset_restart: got fs=%b expected 1", ifa.frameStart); end
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    ifa.enable = 1'b0;
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL areset_pulses: got %0d pending expected 0", exp_q.size()); end
    for (int i = 0; i < 2500 && ifa.busy !== 1'b0; i++) @(negedge clk);
  endtask

  task automatic test_extremes();
    int dt;
    sel = 1; exp_q.delete(); fs_q.delete();
    ifx.dutyIn = {4{8'd255}};
    push_frame(255, 255, 255, 255, 10, 2, 2, 1);
    push_frame(255, 255, 255, 255, 10, 2, 2, 1);
    ifx.enable = 1'b1;
    for (int i = 0; i < 12000 && exp_q.size() != 0; i++) @(negedge clk);
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL xtr_timeout: got %0d pending expected 0", exp_q.size()); end
    dt = (fs_q.size() >= 2) ? int'((fs_q[1] - fs_q[0]) / PERIOD) : -1;
    checks++; if (dt !== XTR_FRAME) begin failures++; $display("FAIL xtr_frame_period: got %0d expected %0d", dt, XTR_FRAME); end
    ifx.enable = 1'b0;
    for (int i = 0; i < 6000 && ifx.busy !== 1'b0; i++) @(negedge clk);
    checks++; if (onehot_bad != 0) begin failures++; $display("FAIL onehot: got %0d violations expected 0", onehot_bad); end
  endtask

  task automatic test_prescaler();
    sel = 2; exp_q.delete(); fs_q.delete();
    ifp.dutyIn = {8'd3, 8'd2, 8'd1, 8'd0};
    push_frame(0, 1, 2, 3, 10, 0, 2, 3);
    ifp.enable = 1'b1;
    for (int i = 0; i < 4000 && exp_q.size() != 0; i++) @(negedge clk);
    ifp.enable = 1'b0;
    checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL presc_timeout: got %0d pending expected 0", exp_q.size()); end
    for (int i = 0; i < 4000 && ifp.busy !== 1'b0; i++) @(negedge clk);
    checks++; if (ifp.busy !== 1'b0) begin failures++; $display("FAIL presc_idle: got busy=%b expected 0", ifp.busy); end
  endtask

  initial begin
    resetN     = 1'b0;
    ifa.enable = 1'b0; ifa.dutyIn = '0;
    ifx.enable = 1'b0; ifx.dutyIn = '0;
    ifp.enable = 1'b0; ifp.dutyIn = '0;
    test_reset();
    test_basic_frame();
    test_shadow_latch();
    test_enable_drop();
    test_async_reset();
    test_extremes();
    test_prescaler();
    checks++; if (onehot_bad != 0) begin failures++; $display("FAIL onehot_final: got %0d violations expected 0", onehot_bad); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
